// File: rtl/uart_console_pkg.sv
// Shared types and constants for the console UART transmitter.
// Holds the FSM encoding, IO slot selects and status bit positions.
package uart_console_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic IO_OUT   = 1'b0;
    localparam logic IO_POWER = 1'b1;

    localparam int FULL      = 0;
    localparam int BUSY      = 1;
    localparam int OVERFLOW  = 2;
    localparam int POWER_REQ = 3;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous 8-bit FIFO with occupancy counter.
// Push is ignored when full, pop is ignored when empty.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] data,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array; contents need no reset since empty gates reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_console_tx.sv
// Memory-mapped console: queues bytes and sends them as 8N1 UART.
// Power-off is acknowledged only once the queue and wire are idle.
module uart_console_tx
    import uart_console_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] memory_in,
    input  logic        address,
    input  logic        write_enable,
    output logic [31:0] memory_out,
    output logic        tx,
    output logic        power_off
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          overflow;
    logic          power_req;
    logic          full;
    logic          empty;
    logic          busy;
    logic [7:0]    head;
    logic          push;
    logic          pop;
    logic          wr_out;
    logic          wr_power;
    logic          unused;

    assign unused   = ^memory_in[31:8];
    assign wr_out   = write_enable && (address == IO_OUT);
    assign wr_power = write_enable && (address == IO_POWER);
    assign push     = wr_out && !full;
    assign pop      = !empty &&
                      ((state == IDLE) ||
                       ((state == STOP) && (cnt == '0)));
    assign busy     = !empty || (state != IDLE);

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .data  (memory_in[7:0]),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    // Status read mux; the POWER slot always reads zero.
    always_comb begin
        memory_out = '0;
        if (address == IO_OUT) begin
            memory_out[FULL]      = full;
            memory_out[BUSY]      = busy;
            memory_out[OVERFLOW]  = overflow;
            memory_out[POWER_REQ] = power_req;
        end
    end

    // Sticky flags: dropped-byte overflow, power request and acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            power_req <= 1'b0;
            power_off <= 1'b0;
        end else begin
            if (wr_out && full) begin
                overflow <= 1'b1;
            end
            if (wr_power) begin
                power_req <= 1'b1;
            end
            if (power_req && empty && (state == IDLE)) begin
                power_off <= 1'b1;
            end
        end
    end

    // Frame sequencer: start bit, 8 data bits LSB first, stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!empty) begin
                        shift <= head;
                        cnt   <= RELOAD;
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        cnt     <= RELOAD;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx      <= shift[0];
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        cnt <= RELOAD;
                        if (bit_idx != 3'd7) begin
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shift[1];
                        end else begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == '0) begin
                        if (!empty) begin
                            shift <= head;
                            cnt   <= RELOAD;
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_console_tx.sv
// Self-checking bench for uart_console_tx with a frame-timeline model.
// Directed scenarios followed by randomized write traffic.
module tb_uart_console_tx;

    localparam int C     = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * C;

    logic        clk;
    logic        rst_n;
    logic [31:0] memory_in;
    logic        address;
    logic        write_enable;
    logic [31:0] memory_out;
    logic        tx;
    logic        power_off;

    int vectors;
    int miscompares;

    // Model: pending bytes, cycles left in current frame, sticky flags.
    logic [7:0] m_q[$];
    int         m_rem;
    logic [7:0] m_cur;
    logic       m_ovf;
    logic       m_preq;
    logic       m_poff;

    uart_console_tx #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .memory_in    (memory_in),
        .address      (address),
        .write_enable (write_enable),
        .memory_out   (memory_out),
        .tx           (tx),
        .power_off    (power_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h",
                     tag, $time, got, exp);
        end
    endtask

    function automatic logic exp_tx();
        int p;
        int b;
        if (m_rem == 0) return 1'b1;
        p = FRAME - m_rem;
        b = p / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_status(input logic a);
        logic [31:0] s;
        s = '0;
        if (a == 1'b0) begin
            s[0] = (m_q.size() == DEPTH);
            s[1] = (m_q.size() != 0) || (m_rem != 0);
            s[2] = m_ovf;
            s[3] = m_preq;
        end
        return s;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_rem  = 0;
        m_cur  = '0;
        m_ovf  = 1'b0;
        m_preq = 1'b0;
        m_poff = 1'b0;
    endtask

    // Advance the model by one rising edge using pre-edge values.
    task automatic model_edge(input logic we, input logic a,
                              input logic [7:0] d);
        bit pre_full;
        bit pre_empty;
        bit pre_idle;
        pre_full  = (m_q.size() == DEPTH);
        pre_empty = (m_q.size() == 0);
        pre_idle  = (m_rem == 0);
        if (m_preq && pre_empty && pre_idle) m_poff = 1'b1;
        if (m_rem <= 1) begin
            if (!pre_empty) begin
                m_cur = m_q.pop_front();
                m_rem = FRAME;
            end else begin
                m_rem = 0;
            end
        end else begin
            m_rem--;
        end
        if (we && a == 1'b0) begin
            if (pre_full) m_ovf = 1'b1;
            else m_q.push_back(d);
        end
        if (we && a == 1'b1) m_preq = 1'b1;
    endtask

    task automatic step(input logic we, input logic a,
                        input logic [7:0] d);
        logic [31:0] din;
        din          = {$urandom} & 32'hFFFF_FF00;
        din[7:0]     = d;
        write_enable = we;
        address      = a;
        memory_in    = din;
        @(posedge clk);
        model_edge(we, a, d);
        #1;
        check("tx", {31'b0, tx}, {31'b0, exp_tx()});
        check("power_off", {31'b0, power_off}, {31'b0, m_poff});
        check("status", memory_out, exp_status(a));
    endtask

    task automatic idle_step();
        step(1'b0, 1'($urandom_range(0, 1)), 8'h00);
    endtask

    task automatic drain(input int extra);
        int n;
        n = 0;
        while ((m_q.size() != 0 || m_rem != 0) && n < 2000) begin
            idle_step();
            n++;
        end
        check("drain_bound", (n < 2000) ? 32'd1 : 32'd0, 32'd1);
        repeat (extra) idle_step();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        address = 1'b0;
        #1;
        model_reset();
        check("rst_tx", {31'b0, tx}, 32'd1);
        check("rst_power_off", {31'b0, power_off}, 32'd0);
        check("rst_status", memory_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        write_enable = 1'b0;
        address      = 1'b0;
        memory_in    = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single byte
        step(1'b1, 1'b0, 8'h41);
        drain(3);

        // Back-to-back frames
        step(1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b0, 8'hAA);
        drain(3);

        // Overflow: six bytes into a depth-4 FIFO
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
        check("ovf_flag", {31'b0, memory_out[2]}, 32'd1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'h00);
        drain(2);
        do_reset();

        // Power drain
        step(1'b1, 1'b0, 8'h48);
        step(1'b1, 1'b0, 8'h49);
        step(1'b1, 1'b1, 8'h00);
        drain(4);
        step(1'b0, 1'b0, 8'h00);
        check("power_done_status", memory_out, 32'h8);
        check("power_done_off", {31'b0, power_off}, 32'd1);
        step(1'b1, 1'b0, 8'h7E);
        drain(3);
        do_reset();

        // Reset mid-frame during a data bit of 0x00
        step(1'b1, 1'b0, 8'h00);
        repeat (12) idle_step();
        check("mid_tx_low", {31'b0, tx}, 32'd0);
        do_reset();
        repeat (60) idle_step();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic we;
            logic a;
            we = ($urandom_range(0, 3) == 0);
            a  = (i > 450) && ($urandom_range(0, 15) == 0);
            step(we, a, 8'($urandom));
        end
        drain(5);
        do_reset();
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 1) == 0), 1'b0, 8'($urandom));
        end
        drain(5);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
